wr_ptr_burst: RTL
=================

Name: wr_ptr_burst

Overview:
FIFO write-side pointer controller, successor to the single-increment write pointer. Accepts 1..MAXW words per handshake beat, which supports packed or bursty producers. Outputs binary and Gray pointers for the read side (same-clock or CDC), a free-space count, almost-full, flush and error reporting. Sits between the upstream AXI-Stream-style producer and the FIFO RAM write port.

Parameters:
ALEN, 8, RAM address width; depth = 2**ALEN.
MAXW, 4, maximum words per beat; must satisfy 1 <= MAXW <= 2**ALEN.
AFULL_TH, 4, o_afull asserts when free words <= AFULL_TH; range 0..2**ALEN.
CW, $clog2(MAXW+1), width of word-count fields (derived; not overridden).

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
i_tvalid  in  1  producer beat valid
i_tcnt  in  CW  words in this beat; legal range 1..MAXW
o_tready  out  1  registered ready; high guarantees a MAXW-word beat fits
i_flush  in  1  single-cycle pulse; empties the FIFO from the write side
i_rptr  in  ALEN+1  binary read pointer, already in the clk domain
o_ram_wen  out  1  RAM write enable (combinational)
o_ram_wcnt  out  CW  words written this cycle; 0 when o_ram_wen=0
o_waddr  out  ALEN  first RAM address of the current beat (= o_wptr[ALEN-1:0])
o_wptr  out  ALEN+1  binary write pointer, registered
o_wptr_gray  out  ALEN+1  Gray encoding of o_wptr, registered in the same cycle
o_free  out  ALEN+1  free words after the registered update, registered
o_afull  out  1  registered almost-full
o_err  out  1  sticky illegal-beat flag

Behaviour:
- Reset (async assert, sync release internally via the FSM): o_wptr=0, o_wptr_gray=0, o_free=2**ALEN, o_afull=(2**ALEN<=AFULL_TH), o_err=0, o_tready=0, state=RST.
- FSM states:
  - RST: o_tready=0. Moves to RUN on the first clk edge with rstn high, so ready rises 1 cycle after the release edge.
  - RUN: normal operation.
  - FLUSH: one cycle with o_tready=0, then returns to RUN.
- Accept = i_tvalid & o_tready & (state==RUN) & ~i_flush.
- Legal = 1 <= i_tcnt <= MAXW.
- o_ram_wen = accept & legal. o_ram_wcnt = o_ram_wen ? i_tcnt : 0.
- An accepted illegal beat is consumed but writes nothing. o_err is set the next cycle and holds until reset or flush.
- Pointer update: wptr_d = o_wptr + o_ram_wcnt, modulo 2**(ALEN+1). Wrap-around is natural; the MSB is the lap bit.
- The RAM writes words at addresses (o_waddr + k) mod 2**ALEN, k = 0..i_tcnt-1. Address wrap within a beat is the RAM wrapper's job.
- used_d = (wptr_d - i_rptr) mod 2**(ALEN+1). free_d = 2**ALEN - used_d.
- Registered outputs:
  - o_free <= free_d.
  - o_afull <= free_d <= AFULL_TH.
  - o_tready <= (state_next==RUN) & (free_d >= MAXW).
- o_tready is conservative: i_rptr only advances, so free only grows between updates, so no overflow is possible. A partial beat never waits for space; the producer waits for MAXW free words.
- Full boundary: free_d==0 means {~wptr_d[ALEN], wptr_d[ALEN-1:0]} == i_rptr. o_tready must be 0 whenever free_d < MAXW.
- Flush (i_flush=1 in any state except RST):
  - o_wptr <= i_rptr, o_free <= 2**ALEN, o_err <= 0, state <= FLUSH.
  - A beat presented in the same cycle is not accepted (o_ram_wen=0).
- Reset mid-operation: all registers return to reset values immediately. A beat in flight is dropped.
- o_wptr_gray = wptr ^ (wptr >> 1), computed from the next value and registered, so it is never skewed from o_wptr.

Decomposition:
- Package wr_ptr_pkg:
  - state enum {RST, RUN, FLUSH} (2-bit).
  - function bin2gray (parameterised by width via a localparam-sized vector, max 32).
  - function beat_legal.
- No sub-module needed; one flat module.

Test Plan (ALEN=3, MAXW=4, AFULL_TH=2):
1. Assert rstn=0 mid-clock, then release -> o_tready=0 on the release edge and 1 one cycle later; o_free=8, o_wptr=0, o_wptr_gray=0.
2. Beats tcnt=3,4 with i_rptr=0 -> o_ram_wcnt 3 then 4; o_wptr 3 then 7; o_free 5 then 1; o_afull=1; o_tready=0 after the second beat.
3. From state 2, step i_rptr to 4 -> o_free=5, o_tready=1. Beat tcnt=4 -> o_wptr=11 (lap bit set), o_waddr=3, o_wptr_gray=0b1110.
4. Accepted beat with i_tcnt=0, then i_tcnt=5 -> o_ram_wen=0, o_wptr unchanged, o_err=1 sticky.
5. Assert i_flush with i_tvalid=1, i_rptr=6 -> o_ram_wen=0; o_wptr=6, o_free=8, o_err=0, o_tready low for one cycle, then 1.
6. Random tcnt/rptr stream over 1000 cycles against a reference model -> never overflows (used<=8), and o_wptr_gray matches bin2gray(o_wptr) every cycle.

Source files
------------

// File: rtl/wr_ptr_pkg.sv
// Shared types and helpers for the burst write-pointer controller.
package wr_ptr_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int GRAY_MAXW = 32;

  // Callers zero-extend into the 32-bit vector and truncate the result.
  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic beat_legal(input int unsigned cnt, input int unsigned maxw);
    return (cnt >= 1) && (cnt <= maxw);
  endfunction

endpackage

// File: rtl/wr_ptr_burst.sv
// FIFO write-side pointer controller accepting 1..MAXW words per beat, with
// binary/Gray pointers, free count, almost-full, flush and sticky error.
module wr_ptr_burst
  import wr_ptr_pkg::*;
#(
  parameter  int ALEN     = 8,
  parameter  int MAXW     = 4,
  parameter  int AFULL_TH = 4,
  localparam int CW       = $clog2(MAXW + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_tvalid,
  input  logic [CW-1:0]   i_tcnt,
  output logic            o_tready,
  input  logic            i_flush,
  input  logic [ALEN:0]   i_rptr,
  output logic            o_ram_wen,
  output logic [CW-1:0]   o_ram_wcnt,
  output logic [ALEN-1:0] o_waddr,
  output logic [ALEN:0]   o_wptr,
  output logic [ALEN:0]   o_wptr_gray,
  output logic [ALEN:0]   o_free,
  output logic            o_afull,
  output logic            o_err
);

  localparam int            PW      = ALEN + 1;
  localparam logic [ALEN:0] DEPTH_V = {1'b1, {ALEN{1'b0}}};
  localparam logic [ALEN:0] MAXW_V  = PW'(MAXW);
  localparam logic [ALEN:0] AF_V    = PW'(AFULL_TH);

  state_e        state_q, state_d;
  logic [ALEN:0] wptr_q, wptr_d, gray_q, gray_d, free_q, free_d, used_d;
  logic          afull_q, tready_q, err_q, err_d;
  logic          flush_eff, accept, legal, wen;

  always_comb begin
    flush_eff = i_flush & (state_q != ST_RST);
    accept    = i_tvalid & tready_q & (state_q == ST_RUN) & ~i_flush;
    legal     = beat_legal(32'(i_tcnt), 32'(MAXW));
    wen       = accept & legal;

    state_d = ST_RUN;
    if (state_q != ST_RST && flush_eff) state_d = ST_FLUSH;

    // Flush re-aligns the write pointer onto the read pointer, emptying the FIFO.
    wptr_d = flush_eff ? i_rptr : wptr_q + (wen ? PW'(i_tcnt) : '0);
    used_d = wptr_d - i_rptr;
    free_d = DEPTH_V - used_d;
    gray_d = PW'(bin2gray(32'(wptr_d)));
    err_d  = flush_eff ? 1'b0 : (err_q | (accept & ~legal));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_RST;
      wptr_q   <= '0;
      gray_q   <= '0;
      free_q   <= DEPTH_V;
      afull_q  <= (DEPTH_V <= AF_V);
      tready_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      gray_q   <= gray_d;
      free_q   <= free_d;
      afull_q  <= (free_d <= AF_V);
      // Read pointer only advances, so free space can only grow until the next update.
      tready_q <= (state_d == ST_RUN) & (free_d >= MAXW_V);
      err_q    <= err_d;
    end
  end

  assign o_tready    = tready_q;
  assign o_ram_wen   = wen;
  assign o_ram_wcnt  = wen ? i_tcnt : '0;
  assign o_waddr     = wptr_q[ALEN-1:0];
  assign o_wptr      = wptr_q;
  assign o_wptr_gray = gray_q;
  assign o_free      = free_q;
  assign o_afull     = afull_q;
  assign o_err       = err_q;

endmodule
